// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: load-use interlock, multi-cycle divider occupancy,
// memory-wait freeze and a saturating stall performance counter.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_is_load,
  input  logic             ex_rf_we,
  input  logic [4:0]       ex_rf_waddr,
  input  logic             ex_div_start,
  input  logic             mem_data_wait,
  input  logic             flush,
  output logic [5:0]       stall,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DIV_CNT_W = 6;
  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 2);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;

  typedef enum logic {
    IDLE,
    DIV_WAIT
  } state_t;

  state_t               r_state;
  logic [DIV_CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0]     r_stall_cycles;

  logic       w_load_use;
  logic       w_div_last;
  logic       w_div_stall;
  logic [5:0] w_stall;

  assign w_load_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rf_waddr)) ||
                       (id_use_rt && (id_rt == ex_rf_waddr)));

  assign w_div_last  = (r_state == DIV_WAIT) && (r_div_cnt == '0);
  // The final divide cycle releases the pipeline so the result can advance.
  assign w_div_stall = ((r_state == DIV_WAIT) && (r_div_cnt != '0)) ||
                       ((r_state == IDLE) && ex_div_start);

  always_comb begin
    w_stall = STALL_NONE;
    if (flush)              w_stall = STALL_NONE;
    else if (mem_data_wait) w_stall = STALL_MEM;
    else if (w_div_stall)   w_stall = STALL_DIV;
    else if (w_load_use)    w_stall = STALL_LU;
  end

  assign stall        = rst ? STALL_NONE : w_stall;
  assign div_busy     = !rst && ((r_state == DIV_WAIT) || ex_div_start);
  assign div_done     = !rst && w_div_last && !flush;
  assign stall_cycles = r_stall_cycles;

  // Divider occupancy FSM; the counter keeps running through memory waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
    end else if (flush) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_div_start) begin
            r_state   <= DIV_WAIT;
            r_div_cnt <= DIV_LOAD;
          end
        end
        DIV_WAIT: begin
          if (r_div_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_div_cnt <= r_div_cnt - DIV_CNT_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_div_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall[0] && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with an expectation queue per cycle.
module tb_pipe_stall_ctrl;

  localparam int unsigned DC = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rf_waddr;
  logic        id_use_rs, id_use_rt, ex_is_load, ex_rf_we;
  logic        ex_div_start, mem_data_wait, flush;
  logic [5:0]  stall, s_stall;
  logic        div_busy, div_done, s_busy, s_done;
  logic [31:0] stall_cycles;
  logic [1:0]  s_cycles;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cnt_model = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(DC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_is_load(ex_is_load),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_div_start(ex_div_start),
    .mem_data_wait(mem_data_wait), .flush(flush), .stall(stall),
    .div_busy(div_busy), .div_done(div_done), .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance for the saturation boundary.
  pipe_stall_ctrl #(.DIV_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_is_load(ex_is_load),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_div_start(ex_div_start),
    .mem_data_wait(mem_data_wait), .flush(flush), .stall(s_stall),
    .div_busy(s_busy), .div_done(s_done), .stall_cycles(s_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_is_load = 0; ex_rf_we = 0; ex_rf_waddr = 0;
    ex_div_start = 0; mem_data_wait = 0; flush = 0;
  endtask

  task automatic set_load(input logic [4:0] wa);
    ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = wa;
  endtask

  // Called right after a falling edge with inputs driven; ends at the next falling edge.
  task automatic step(input string tag, input logic [5:0] es, input logic eb, input logic ed);
    exp_t e;
    q.push_back('{tag, es, eb, ed, cnt_model});
    #2;
    e = q.pop_front();
    chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
    chk({e.tag, ".busy"},  32'(div_busy), 32'(e.busy));
    chk({e.tag, ".done"},  32'(div_done), 32'(e.done));
    chk({e.tag, ".cnt"},   stall_cycles, e.cnt);
    @(negedge clk);
    if (e.stall[0] && cnt_model != '1) cnt_model++;
  endtask

  task automatic divide_run(input string tag, input int fa, input int wa, input bit hold);
    for (int c = 1; c <= int'(DC); c++) begin
      ex_div_start  = hold ? 1'b1 : (c == 1);
      flush         = (c == fa);
      mem_data_wait = (wa != 0) && (c >= wa) && (c < wa + 3);
      if (fa != 0 && c > fa)   step($sformatf("%s_c%0d", tag, c), 6'b000000, 0, 0);
      else if (c == fa)        step($sformatf("%s_c%0d", tag, c), 6'b000000, 1, 0);
      else if (mem_data_wait)  step($sformatf("%s_c%0d", tag, c), 6'b011111, 1, 0);
      else if (c == int'(DC))  step($sformatf("%s_c%0d", tag, c), 6'b000000, 1, 1);
      else                     step($sformatf("%s_c%0d", tag, c), 6'b001111, 1, 0);
    end
    clear_inputs();
    step({tag, "_after"}, 6'b000000, 0, 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    ex_div_start = 1;
    set_load(5'd5); id_rs = 5'd5; id_use_rs = 1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.busy",  32'(div_busy), 0);
    chk("rst.done",  32'(div_done), 0);
    chk("rst.cnt",   stall_cycles, 0);
    @(negedge clk);
    clear_inputs();
    rst = 0;

    // Load-use on rs, then the bubble clears it.
    set_load(5'd5); id_rs = 5'd5; id_use_rs = 1;
    step("lu_rs", 6'b000111, 0, 0);
    clear_inputs();
    step("lu_rs_next", 6'b000000, 0, 0);
    set_load(5'd9); id_rt = 5'd9; id_use_rt = 1;
    step("lu_rt", 6'b000111, 0, 0);
    id_use_rt = 0;
    step("lu_rt_unused", 6'b000000, 0, 0);
    clear_inputs();
    set_load(5'd0); id_rs = 5'd0; id_use_rs = 1;
    step("lu_r0", 6'b000000, 0, 0);
    clear_inputs();
    set_load(5'd7); ex_rf_we = 0; id_rs = 5'd7; id_use_rs = 1;
    step("lu_nowe", 6'b000000, 0, 0);
    ex_rf_we = 1; mem_data_wait = 1;
    step("lu_wait", 6'b011111, 0, 0);
    mem_data_wait = 0;
    step("lu_after_wait", 6'b000111, 0, 0);
    flush = 1;
    step("lu_flush", 6'b000000, 0, 0);
    clear_inputs();

    divide_run("div", 0, 0, 0);
    divide_run("divwait", 0, 10, 0);
    divide_run("divflush", 5, 0, 0);
    divide_run("divhold", 0, 0, 1);

    // Asynchronous reset in the middle of a divide.
    ex_div_start = 1;
    step("rdiv_c1", 6'b001111, 1, 0);
    ex_div_start = 0;
    for (int c = 2; c <= 4; c++) step($sformatf("rdiv_c%0d", c), 6'b001111, 1, 0);
    #2;
    rst = 1;
    ex_div_start = 1;
    #1;
    chk("arst.stall", 32'(stall), 0);
    chk("arst.busy",  32'(div_busy), 0);
    chk("arst.done",  32'(div_done), 0);
    chk("arst.cnt",   stall_cycles, 0);
    chk("arst.sat_cnt", 32'(s_cycles), 0);
    chk("arst.sat_out", {25'd0, s_stall, s_busy}, 0);
    @(negedge clk);
    chk("arst_hold.stall", 32'(stall), 0);
    chk("arst_hold.done", 32'(s_done | div_done), 0);
    rst = 0;
    ex_div_start = 0;
    cnt_model = 0;
    step("post_rst", 6'b000000, 0, 0);
    divide_run("div2", 0, 0, 0);

    // Narrow counter must sit at all-ones rather than wrap.
    set_load(5'd3); id_rs = 5'd3; id_use_rs = 1;
    for (int i = 0; i < 4; i++) step($sformatf("lu_sat%0d", i), 6'b000111, 0, 0);
    clear_inputs();
    #2;
    chk("sat_cnt", 32'(s_cycles), 3);
    chk("final_cnt", stall_cycles, cnt_model);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
